mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the single backing-memory port between the instruction cache (requester 0) and the data cache (requester 1). It sits between both cache miss/write-back interfaces and the memory model. It serialises line-fill reads and dirty write-backs as one outstanding transaction at a time. It routes each memory response back to the requester that issued the request.

## Interface
Parameters:
- ADDR_W, 10, line-address width (tag bits concatenated with index bits; no byte offset).
- LINE_W, 128, line data width in bits.
- MASK_W, LINE_W/8, write byte-mask width.

Ports (cN_ = requester N, N = 0 for I-cache, 1 for D-cache):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cN_r_req_valid / cN_r_req_ready  in / out  1 / 1  read request handshake.
- cN_r_req_addr  in  ADDR_W  read line address.
- cN_r_resp_valid  out  1  read data valid to requester N.
- cN_r_resp_rdata  out  LINE_W  read line data; broadcast to both requesters, qualified only by cN_r_resp_valid.
- cN_w_req_valid / cN_w_req_ready  in / out  1 / 1  write request handshake.
- cN_w_req_addr / cN_w_req_data / cN_w_req_wmask  in  ADDR_W / LINE_W / MASK_W  write payload.
- cN_w_resp_valid  out  1  write completion to requester N.
- mem_r_req_valid / mem_r_req_ready  out / in  1 / 1, plus mem_r_req_addr  out  ADDR_W.
- mem_r_resp_valid / mem_r_resp_rdata  in  1 / LINE_W.
- mem_w_req_valid / mem_w_req_ready  out / in  1 / 1, plus mem_w_req_addr / mem_w_req_data / mem_w_req_wmask  out.
- mem_w_resp_valid  in  1.
- busy  out  1  state != IDLE.
- owner  out  1  requester holding the grant; valid only while busy.
- proto_err  out  1  sticky; memory response received outside WAIT.

## Operation
- FSM states: IDLE, REQ, WAIT. Registered state: owner, is_write, last_owner.
- IDLE: if any of the four cN_*_req_valid is high, arbitrate and latch owner/is_write, then go to REQ. No outputs are asserted in IDLE.
  - Between requesters: fixed priority, requester 1 wins (see Configuration).
  - Within the winning requester: write beats read, so a write-back precedes its line fill.
- REQ: drive mem_r_req_* or mem_w_req_* (selected by is_write) with the owner's live payload.
  - Payload is muxed combinationally; requesters hold the payload stable until ready.
  - Owner's matching ready = corresponding mem_*_req_ready. All other readies = 0.
  - On handshake (valid & ready), go to WAIT.
  - If the owner drops valid before the handshake, return to IDLE without a memory request.
- WAIT: the matching memory response (mem_r_resp_valid or mem_w_resp_valid) is passed combinationally to the owner's cN_*_resp_valid only. It then goes to IDLE. The non-matching response type sets proto_err.
- last_owner is updated on every REQ→WAIT transition.
- Any mem_*_resp_valid in IDLE or REQ sets proto_err and is not forwarded.

## Timing
- Reset values: state=IDLE, last_owner=1, proto_err=0. All valid/ready outputs, busy and owner are 0. Data/addr/mask outputs are 0 outside REQ.
- Request seen in IDLE at cycle T → mem_*_req_valid at T+1 (one-cycle arbitration latency).
- Response at cycle T → cN_*_resp_valid at T (zero latency); arbiter is in IDLE at T+1 and can grant at T+1, issuing at T+2.
- Minimum transaction turnaround: 3 cycles (IDLE, REQ with immediate ready, WAIT with same-cycle response is not allowed; response ≥1 cycle after handshake).
- Simultaneous requests from both requesters in IDLE: a single winner; the loser stays pending with ready=0.
- Reset mid-REQ/WAIT: return to IDLE next edge and drop the transaction. A stale memory response arriving afterwards sets proto_err.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On conflict, the requester != last_owner wins. After reset, requester 0 wins the first conflict.
- Not defined: fixed priority, requester 1 (D-cache) always wins. last_owner is still tracked but unused.

## Test plan
- Single read: c0_r_req_valid=1, addr=0x2A3, mem ready immediately, rdata returned 2 cycles later → mem_r_req_addr=0x2A3 one cycle after request; c0_r_resp_valid pulses with that rdata; c1_r_resp_valid stays 0.
- Write-then-read same requester: c1_w and c1_r valid together → write issued first (wmask=all-ones passes through). The read is issued only after mem_w_resp_valid.
- Conflict: c0_r and c1_r valid in same cycle, three back-to-back rounds → without macro, c1 granted every time while it keeps requesting. With MEM_ARB_RR_EN, the grants are c0, c1, c0.
- Backpressure: mem_r_req_ready held 0 for 5 cycles → mem_r_req_valid and the address stay stable; c0_r_req_ready=0 until the ready cycle.
- Spurious response: mem_r_resp_valid pulsed in IDLE → proto_err=1 and stays 1; no cN_r_resp_valid.
- Reset in WAIT: assert rst for 1 cycle → busy=0 next cycle; a new c0 read is then granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one backing-memory port between I-cache (c0) and D-cache (c1)
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration; fixed priority to c1 when undefined)
module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int LINE_W = 128,
  parameter int MASK_W = LINE_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_r_req_valid,
  output logic              c0_r_req_ready,
  input  logic [ADDR_W-1:0] c0_r_req_addr,
  output logic              c0_r_resp_valid,
  output logic [LINE_W-1:0] c0_r_resp_rdata,
  input  logic              c0_w_req_valid,
  output logic              c0_w_req_ready,
  input  logic [ADDR_W-1:0] c0_w_req_addr,
  input  logic [LINE_W-1:0] c0_w_req_data,
  input  logic [MASK_W-1:0] c0_w_req_wmask,
  output logic              c0_w_resp_valid,
  input  logic              c1_r_req_valid,
  output logic              c1_r_req_ready,
  input  logic [ADDR_W-1:0] c1_r_req_addr,
  output logic              c1_r_resp_valid,
  output logic [LINE_W-1:0] c1_r_resp_rdata,
  input  logic              c1_w_req_valid,
  output logic              c1_w_req_ready,
  input  logic [ADDR_W-1:0] c1_w_req_addr,
  input  logic [LINE_W-1:0] c1_w_req_data,
  input  logic [MASK_W-1:0] c1_w_req_wmask,
  output logic              c1_w_resp_valid,
  output logic              mem_r_req_valid,
  input  logic              mem_r_req_ready,
  output logic [ADDR_W-1:0] mem_r_req_addr,
  input  logic              mem_r_resp_valid,
  input  logic [LINE_W-1:0] mem_r_resp_rdata,
  output logic              mem_w_req_valid,
  input  logic              mem_w_req_ready,
  output logic [ADDR_W-1:0] mem_w_req_addr,
  output logic [LINE_W-1:0] mem_w_req_data,
  output logic [MASK_W-1:0] mem_w_req_wmask,
  input  logic              mem_w_resp_valid,
  output logic              busy,
  output logic              owner,
  output logic              proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   is_write_q, is_write_d;
  logic   last_owner_q, last_owner_d;
  logic   proto_err_q, proto_err_d;

  logic c0_any, c1_any, grant, own_valid;

  assign c0_any = c0_r_req_valid | c0_w_req_valid;
  assign c1_any = c1_r_req_valid | c1_w_req_valid;

  // Read data is broadcast; each requester qualifies it with its own resp_valid
  assign c0_r_resp_rdata = mem_r_resp_rdata;
  assign c1_r_resp_rdata = mem_r_resp_rdata;

  assign busy      = (state_q != S_IDLE);
  assign owner     = busy & owner_q;
  assign proto_err = proto_err_q;

  // Requester selection between c0 and c1 on a new arbitration
`ifdef MEM_ARB_RR_EN
  assign grant = (c0_any && c1_any) ? ~last_owner_q : c1_any;
`else
  assign grant = c1_any;
`endif

  // Owner's live valid for the latched transaction type
  assign own_valid = is_write_q ? (owner_q ? c1_w_req_valid : c0_w_req_valid)
                                : (owner_q ? c1_r_req_valid : c0_r_req_valid);

  // State and transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      is_write_q   <= 1'b0;
      last_owner_q <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      is_write_q   <= is_write_d;
      last_owner_q <= last_owner_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Next-state logic plus request/response routing
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    is_write_d      = is_write_q;
    last_owner_d    = last_owner_q;
    proto_err_d     = proto_err_q;
    c0_r_req_ready  = 1'b0;
    c1_r_req_ready  = 1'b0;
    c0_w_req_ready  = 1'b0;
    c1_w_req_ready  = 1'b0;
    c0_r_resp_valid = 1'b0;
    c1_r_resp_valid = 1'b0;
    c0_w_resp_valid = 1'b0;
    c1_w_resp_valid = 1'b0;
    mem_r_req_valid = 1'b0;
    mem_r_req_addr  = '0;
    mem_w_req_valid = 1'b0;
    mem_w_req_addr  = '0;
    mem_w_req_data  = '0;
    mem_w_req_wmask = '0;

    // Responses are only legal while waiting for one
    if (state_q != S_WAIT && (mem_r_resp_valid || mem_w_resp_valid)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (c0_any || c1_any) begin
          owner_d    = grant;
          is_write_d = grant ? c1_w_req_valid : c0_w_req_valid;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (!own_valid) begin
          state_d = S_IDLE;
        end else if (is_write_q) begin
          mem_w_req_valid = 1'b1;
          mem_w_req_addr  = owner_q ? c1_w_req_addr  : c0_w_req_addr;
          mem_w_req_data  = owner_q ? c1_w_req_data  : c0_w_req_data;
          mem_w_req_wmask = owner_q ? c1_w_req_wmask : c0_w_req_wmask;
          c1_w_req_ready  = owner_q & mem_w_req_ready;
          c0_w_req_ready  = ~owner_q & mem_w_req_ready;
          if (mem_w_req_ready) begin
            state_d      = S_WAIT;
            last_owner_d = owner_q;
          end
        end else begin
          mem_r_req_valid = 1'b1;
          mem_r_req_addr  = owner_q ? c1_r_req_addr : c0_r_req_addr;
          c1_r_req_ready  = owner_q & mem_r_req_ready;
          c0_r_req_ready  = ~owner_q & mem_r_req_ready;
          if (mem_r_req_ready) begin
            state_d      = S_WAIT;
            last_owner_d = owner_q;
          end
        end
      end
      S_WAIT: begin
        if (is_write_q) begin
          if (mem_w_resp_valid) begin
            c1_w_resp_valid = owner_q;
            c0_w_resp_valid = ~owner_q;
            state_d         = S_IDLE;
          end
          if (mem_r_resp_valid) proto_err_d = 1'b1;
        end else begin
          if (mem_r_resp_valid) begin
            c1_r_resp_valid = owner_q;
            c0_r_resp_valid = ~owner_q;
            state_d         = S_IDLE;
          end
          if (mem_w_resp_valid) proto_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int LINE_W = 128;
  localparam int MASK_W = LINE_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c0_r_req_valid = 0, c0_r_req_ready;
  logic [ADDR_W-1:0] c0_r_req_addr = '0;
  logic c0_r_resp_valid;
  logic [LINE_W-1:0] c0_r_resp_rdata;
  logic c0_w_req_valid = 0, c0_w_req_ready;
  logic [ADDR_W-1:0] c0_w_req_addr = '0;
  logic [LINE_W-1:0] c0_w_req_data = '0;
  logic [MASK_W-1:0] c0_w_req_wmask = '0;
  logic c0_w_resp_valid;
  logic c1_r_req_valid = 0, c1_r_req_ready;
  logic [ADDR_W-1:0] c1_r_req_addr = '0;
  logic c1_r_resp_valid;
  logic [LINE_W-1:0] c1_r_resp_rdata;
  logic c1_w_req_valid = 0, c1_w_req_ready;
  logic [ADDR_W-1:0] c1_w_req_addr = '0;
  logic [LINE_W-1:0] c1_w_req_data = '0;
  logic [MASK_W-1:0] c1_w_req_wmask = '0;
  logic c1_w_resp_valid;
  logic mem_r_req_valid, mem_r_req_ready = 0;
  logic [ADDR_W-1:0] mem_r_req_addr;
  logic mem_r_resp_valid = 0;
  logic [LINE_W-1:0] mem_r_resp_rdata = '0;
  logic mem_w_req_valid, mem_w_req_ready = 0;
  logic [ADDR_W-1:0] mem_w_req_addr;
  logic [LINE_W-1:0] mem_w_req_data;
  logic [MASK_W-1:0] mem_w_req_wmask;
  logic mem_w_resp_valid = 0;
  logic busy, owner, proto_err;

  typedef struct {
    logic              w;
    logic              who;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .c0_r_req_valid(c0_r_req_valid), .c0_r_req_ready(c0_r_req_ready), .c0_r_req_addr(c0_r_req_addr),
    .c0_r_resp_valid(c0_r_resp_valid), .c0_r_resp_rdata(c0_r_resp_rdata),
    .c0_w_req_valid(c0_w_req_valid), .c0_w_req_ready(c0_w_req_ready), .c0_w_req_addr(c0_w_req_addr),
    .c0_w_req_data(c0_w_req_data), .c0_w_req_wmask(c0_w_req_wmask), .c0_w_resp_valid(c0_w_resp_valid),
    .c1_r_req_valid(c1_r_req_valid), .c1_r_req_ready(c1_r_req_ready), .c1_r_req_addr(c1_r_req_addr),
    .c1_r_resp_valid(c1_r_resp_valid), .c1_r_resp_rdata(c1_r_resp_rdata),
    .c1_w_req_valid(c1_w_req_valid), .c1_w_req_ready(c1_w_req_ready), .c1_w_req_addr(c1_w_req_addr),
    .c1_w_req_data(c1_w_req_data), .c1_w_req_wmask(c1_w_req_wmask), .c1_w_resp_valid(c1_w_resp_valid),
    .mem_r_req_valid(mem_r_req_valid), .mem_r_req_ready(mem_r_req_ready), .mem_r_req_addr(mem_r_req_addr),
    .mem_r_resp_valid(mem_r_resp_valid), .mem_r_resp_rdata(mem_r_resp_rdata),
    .mem_w_req_valid(mem_w_req_valid), .mem_w_req_ready(mem_w_req_ready), .mem_w_req_addr(mem_w_req_addr),
    .mem_w_req_data(mem_w_req_data), .mem_w_req_wmask(mem_w_req_wmask), .mem_w_resp_valid(mem_w_resp_valid),
    .busy(busy), .owner(owner), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every memory-side handshake must match the oldest expected request
  always @(negedge clk) begin
    if (!rst && ((mem_r_req_valid && mem_r_req_ready) || (mem_w_req_valid && mem_w_req_ready))) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: r=%0b w=%0b addr_r=%0h addr_w=%0h, required no request",
                 mem_r_req_valid, mem_w_req_valid, mem_r_req_addr, mem_w_req_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.w == 1'b0 && (mem_w_req_valid || mem_r_req_addr !== e.addr || owner !== e.who)) begin
          errors++;
          $display("FAIL sb_read: w=%0b addr=%0h owner=%0b, required read addr=%0h owner=%0b",
                   mem_w_req_valid, mem_r_req_addr, owner, e.addr, e.who);
        end else if (e.w == 1'b1 && (mem_r_req_valid || mem_w_req_addr !== e.addr || owner !== e.who ||
                                     mem_w_req_data !== e.data || mem_w_req_wmask !== e.mask)) begin
          errors++;
          $display("FAIL sb_write: r=%0b addr=%0h owner=%0b data=%0h mask=%0h, required addr=%0h owner=%0b data=%0h mask=%0h",
                   mem_r_req_valid, mem_w_req_addr, owner, mem_w_req_data, mem_w_req_wmask,
                   e.addr, e.who, e.data, e.mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic who, input logic [ADDR_W-1:0] a,
                      input logic [LINE_W-1:0] d, input logic [MASK_W-1:0] m);
    exp_t e;
    e.w = w; e.who = who; e.addr = a; e.data = d; e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, owner, proto_err} !== 3'b000) begin
      errors++; $display("FAIL reset_status: busy/owner/err=%b, required 000", {busy, owner, proto_err});
    end
    checks++;
    if ({c0_r_req_ready, c1_r_req_ready, c0_w_req_ready, c1_w_req_ready, mem_r_req_valid, mem_w_req_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes: got nonzero ready/valid, required all 0");
    end
    checks++;
    if ({mem_r_req_addr, mem_w_req_addr, mem_w_req_wmask} !== '0 || mem_w_req_data !== '0) begin
      errors++; $display("FAIL reset_payload: raddr=%0h waddr=%0h, required 0", mem_r_req_addr, mem_w_req_addr);
    end
  endtask

  task automatic test_single_read();
    c0_r_req_addr = 10'h2A3; c0_r_req_valid = 1'b1; mem_r_req_ready = 1'b1;
    push(1'b0, 1'b0, 10'h2A3, '0, '0);
    #1;
    checks++;
    if (mem_r_req_valid !== 1'b0 || c0_r_req_ready !== 1'b0) begin
      errors++; $display("FAIL read_idle_quiet: mem_valid=%b ready=%b, required 0 0", mem_r_req_valid, c0_r_req_ready);
    end
    tick();
    checks++;
    if (mem_r_req_valid !== 1'b1 || mem_r_req_addr !== 10'h2A3 || c0_r_req_ready !== 1'b1) begin
      errors++; $display("FAIL read_issue: valid=%b addr=%0h ready=%b, required 1 2a3 1", mem_r_req_valid, mem_r_req_addr, c0_r_req_ready);
    end
    tick();
    c0_r_req_valid = 1'b0;
    tick();
    mem_r_resp_valid = 1'b1; mem_r_resp_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    checks++;
    if (c0_r_resp_valid !== 1'b1 || c1_r_resp_valid !== 1'b0 ||
        c0_r_resp_rdata !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) begin
      errors++; $display("FAIL read_resp: c0=%b c1=%b data=%0h, required 1 0 0123456789abcdeffedcba9876543210",
                         c0_r_resp_valid, c1_r_resp_valid, c0_r_resp_rdata);
    end
    tick();
    mem_r_resp_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL read_done: busy=%b err=%b, required 0 0", busy, proto_err);
    end
  endtask

  task automatic test_write_then_read();
    c1_w_req_addr = 10'h155; c1_w_req_data = {4{32'hDEAD_BEEF}}; c1_w_req_wmask = '1; c1_w_req_valid = 1'b1;
    c1_r_req_addr = 10'h0F0; c1_r_req_valid = 1'b1;
    mem_w_req_ready = 1'b1; mem_r_req_ready = 1'b1;
    push(1'b1, 1'b1, 10'h155, {4{32'hDEAD_BEEF}}, '1);
    push(1'b0, 1'b1, 10'h0F0, '0, '0);
    tick();
    checks++;
    if (mem_w_req_valid !== 1'b1 || mem_r_req_valid !== 1'b0 || c1_w_req_ready !== 1'b1 ||
        c1_r_req_ready !== 1'b0 || mem_w_req_wmask !== 16'hFFFF || owner !== 1'b1) begin
      errors++; $display("FAIL wr_first: wv=%b rv=%b wrdy=%b rrdy=%b mask=%0h owner=%b, required 1 0 1 0 ffff 1",
                         mem_w_req_valid, mem_r_req_valid, c1_w_req_ready, c1_r_req_ready, mem_w_req_wmask, owner);
    end
    tick();
    c1_w_req_valid = 1'b0;
    tick();
    checks++;
    if (mem_r_req_valid !== 1'b0 || c1_r_req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wr_blocks_read: rv=%b rrdy=%b busy=%b, required 0 0 1", mem_r_req_valid, c1_r_req_ready, busy);
    end
    mem_w_resp_valid = 1'b1;
    #1;
    checks++;
    if (c1_w_resp_valid !== 1'b1 || c0_w_resp_valid !== 1'b0) begin
      errors++; $display("FAIL wr_resp: c1=%b c0=%b, required 1 0", c1_w_resp_valid, c0_w_resp_valid);
    end
    tick();
    mem_w_resp_valid = 1'b0;
    tick();
    checks++;
    if (mem_r_req_valid !== 1'b1 || mem_r_req_addr !== 10'h0F0) begin
      errors++; $display("FAIL wr_then_rd: rv=%b addr=%0h, required 1 0f0", mem_r_req_valid, mem_r_req_addr);
    end
    tick();
    c1_r_req_valid = 1'b0;
    mem_r_resp_valid = 1'b1; mem_r_resp_rdata = 128'h5A;
    #1;
    checks++;
    if (c1_r_resp_valid !== 1'b1 || c0_r_resp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_after_wr_resp: c1=%b c0=%b, required 1 0", c1_r_resp_valid, c0_r_resp_valid);
    end
    tick();
    mem_r_resp_valid = 1'b0;
    mem_w_req_ready = 1'b0;
  endtask

  task automatic test_conflict();
    logic win;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    c0_r_req_addr = 10'h111; c1_r_req_addr = 10'h222; mem_r_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
`ifdef MEM_ARB_RR_EN
      win = (i % 2 == 1);
`else
      win = 1'b1;
`endif
      c0_r_req_valid = 1'b1; c1_r_req_valid = 1'b1;
      push(1'b0, win, win ? 10'h222 : 10'h111, '0, '0);
      tick();
      checks++;
      if (owner !== win || (win ? c0_r_req_ready : c1_r_req_ready) !== 1'b0 ||
          (win ? c1_r_req_ready : c0_r_req_ready) !== 1'b1) begin
        errors++; $display("FAIL conflict_grant round %0d: owner=%b rdy0=%b rdy1=%b, required owner=%b",
                           i, owner, c0_r_req_ready, c1_r_req_ready, win);
      end
      tick();
      if (win) c1_r_req_valid = 1'b0; else c0_r_req_valid = 1'b0;
      tick();
      mem_r_resp_valid = 1'b1; mem_r_resp_rdata = 128'(i + 7);
      #1;
      checks++;
      if ((win ? c1_r_resp_valid : c0_r_resp_valid) !== 1'b1 || (win ? c0_r_resp_valid : c1_r_resp_valid) !== 1'b0) begin
        errors++; $display("FAIL conflict_resp round %0d: c0=%b c1=%b, required winner %b only",
                           i, c0_r_resp_valid, c1_r_resp_valid, win);
      end
      tick();
      mem_r_resp_valid = 1'b0;
    end
    c0_r_req_valid = 1'b0; c1_r_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    c0_r_req_addr = 10'h3C5; c0_r_req_valid = 1'b1; mem_r_req_ready = 1'b0;
    push(1'b0, 1'b0, 10'h3C5, '0, '0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_r_req_valid !== 1'b1 || mem_r_req_addr !== 10'h3C5 || c0_r_req_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure cycle %0d: valid=%b addr=%0h ready=%b, required 1 3c5 0",
                           i, mem_r_req_valid, mem_r_req_addr, c0_r_req_ready);
      end
      tick();
    end
    mem_r_req_ready = 1'b1;
    #1;
    checks++;
    if (c0_r_req_ready !== 1'b1) begin
      errors++; $display("FAIL backpressure_release: ready=%b, required 1", c0_r_req_ready);
    end
    tick();
    c0_r_req_valid = 1'b0;
    mem_r_resp_valid = 1'b1;
    tick();
    mem_r_resp_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL backpressure_done: busy=%b err=%b, required 0 0", busy, proto_err);
    end
  endtask

  task automatic test_spurious();
    mem_r_resp_valid = 1'b1;
    #1;
    checks++;
    if (c0_r_resp_valid !== 1'b0 || c1_r_resp_valid !== 1'b0) begin
      errors++; $display("FAIL spurious_fwd: c0=%b c1=%b, required 0 0", c0_r_resp_valid, c1_r_resp_valid);
    end
    tick();
    mem_r_resp_valid = 1'b0;
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL spurious_err: err=%b, required 1", proto_err);
    end
    tick();
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++; $display("FAIL spurious_sticky: err=%b, required 1", proto_err);
    end
  endtask

  task automatic test_reset_in_wait();
    c0_r_req_addr = 10'h077; c0_r_req_valid = 1'b1; mem_r_req_ready = 1'b1;
    push(1'b0, 1'b0, 10'h077, '0, '0);
    tick();
    tick();
    c0_r_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL rst_wait: busy=%b err=%b, required 0 0", busy, proto_err);
    end
    c0_r_req_addr = 10'h0AB; c0_r_req_valid = 1'b1;
    push(1'b0, 1'b0, 10'h0AB, '0, '0);
    tick();
    checks++;
    if (mem_r_req_valid !== 1'b1 || mem_r_req_addr !== 10'h0AB || owner !== 1'b0) begin
      errors++; $display("FAIL rst_regrant: valid=%b addr=%0h owner=%b, required 1 0ab 0", mem_r_req_valid, mem_r_req_addr, owner);
    end
    tick();
    c0_r_req_valid = 1'b0;
    mem_r_resp_valid = 1'b1;
    #1;
    checks++;
    if (c0_r_resp_valid !== 1'b1) begin
      errors++; $display("FAIL rst_regrant_resp: c0=%b, required 1", c0_r_resp_valid);
    end
    tick();
    tick();
    checks++;
    if (proto_err !== 1'b1 || c0_r_resp_valid !== 1'b0) begin
      errors++; $display("FAIL stale_resp: err=%b c0=%b, required 1 0", proto_err, c0_r_resp_valid);
    end
    mem_r_resp_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_conflict();
    test_backpressure();
    test_spurious();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d requests never issued, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
